// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game of Life generation sequencer.
// The GOL_TORUS_EN macro (see gol_row_rule / gol_next_gen) selects toroidal wrap.
package gol_pkg;

  localparam int GOL_WIDTH   = 8;
  localparam int GOL_REGBITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_PRV = 3'd1,
    ST_LOAD_CUR = 3'd2,
    ST_LOAD_NXT = 3'd3,
    ST_STEP     = 3'd4,
    ST_DONE     = 3'd5
  } gol_state_e;

  function automatic logic gol_rule(input logic alive, input logic [3:0] cnt);
    if (alive) return (cnt == 4'd2) || (cnt == 4'd3);
    else       return (cnt == 4'd3);
  endfunction

endpackage

// File: rtl/gol_row_rule.sv
// Combinational next-generation row from a three-row window.
// GOL_TORUS_EN wraps bit 0 and bit WIDTH-1 into each other; otherwise edges are dead.
module gol_row_rule
  import gol_pkg::*;
#(
  parameter int WIDTH = GOL_WIDTH
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] nxt_i,
  output logic [WIDTH-1:0] row_o
);

  // Row x sits at ext[WIDTH:1]; ext[0] and ext[WIDTH+1] are the horizontal edge neighbours.
  logic [WIDTH+1:0] p_ext, c_ext, n_ext;
  logic [3:0]       cnt;

`ifdef GOL_TORUS_EN
  assign p_ext = {prev_i[0], prev_i, prev_i[WIDTH-1]};
  assign c_ext = {cur_i[0],  cur_i,  cur_i[WIDTH-1]};
  assign n_ext = {nxt_i[0],  nxt_i,  nxt_i[WIDTH-1]};
`else
  assign p_ext = {1'b0, prev_i, 1'b0};
  assign c_ext = {1'b0, cur_i,  1'b0};
  assign n_ext = {1'b0, nxt_i,  1'b0};
`endif

  always_comb begin
    row_o = '0;
    cnt   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = 4'(p_ext[i]) + 4'(p_ext[i+1]) + 4'(p_ext[i+2])
          + 4'(c_ext[i])                  + 4'(c_ext[i+2])
          + 4'(n_ext[i]) + 4'(n_ext[i+1]) + 4'(n_ext[i+2]);
      row_o[i] = gol_rule(cur_i[i], cnt);
    end
  end

endmodule

// File: rtl/gol_next_gen.sv
// Generation-step sequencer: sweeps the row store once per start, writing each next-gen row in place.
// GOL_TORUS_EN adds LOAD_PRV and row0_save so the grid wraps vertically and horizontally.
module gol_next_gen
  import gol_pkg::*;
#(
  parameter int WIDTH   = GOL_WIDTH,
  parameter int REGBITS = GOL_REGBITS,
  parameter int CNTW    = 16
) (
  input  logic               ph2,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   rd,
  output logic [REGBITS-1:0] ra,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  output logic               regwrite,
  output logic               busy,
  output logic               done,
  output logic [CNTW-1:0]    gen_count
);

  localparam int ROWS = 2**REGBITS;
  localparam logic [REGBITS-1:0] LAST_ROW = REGBITS'(ROWS - 1);

  gol_state_e         state_q, state_d;
  logic [REGBITS-1:0] row_q, row_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   cur_q, cur_d;
  logic [WIDTH-1:0]   nxt_q, nxt_d;
  logic [CNTW-1:0]    gen_count_q, gen_count_d;
`ifdef GOL_TORUS_EN
  logic [WIDTH-1:0]   row0_save_q, row0_save_d;
`endif

  logic [REGBITS-1:0] row_plus2;
  logic               row_plus2_fits;
  logic [WIDTH-1:0]   rule_row;

  assign row_plus2      = row_q + REGBITS'(2);
  assign row_plus2_fits = ({1'b0, row_q} + (REGBITS+1)'(2)) < (REGBITS+1)'(ROWS);

  gol_row_rule #(.WIDTH(WIDTH)) u_rule (
    .prev_i (prev_q),
    .cur_i  (cur_q),
    .nxt_i  (nxt_q),
    .row_o  (rule_row)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    gen_count_d = gen_count_q;
`ifdef GOL_TORUS_EN
    row0_save_d = row0_save_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef GOL_TORUS_EN
          state_d = ST_LOAD_PRV;
`else
          state_d = ST_LOAD_CUR;
`endif
        end
      end
`ifdef GOL_TORUS_EN
      ST_LOAD_PRV: begin
        prev_d  = rd;
        state_d = ST_LOAD_CUR;
      end
`endif
      ST_LOAD_CUR: begin
        cur_d = rd;
        row_d = '0;
`ifdef GOL_TORUS_EN
        row0_save_d = rd;
`else
        prev_d = '0;
`endif
        state_d = ST_LOAD_NXT;
      end
      ST_LOAD_NXT: begin
        nxt_d   = rd;
        state_d = ST_STEP;
      end
      ST_STEP: begin
        prev_d = cur_q;
        cur_d  = nxt_q;
`ifdef GOL_TORUS_EN
        // The row below the last one is the original row 0, already overwritten in the store.
        if (row_plus2_fits)                    nxt_d = rd;
        else if (row_q == REGBITS'(ROWS - 2))  nxt_d = row0_save_q;
        else                                   nxt_d = '0;
`else
        nxt_d = row_plus2_fits ? rd : '0;
`endif
        if (row_q == LAST_ROW) state_d = ST_DONE;
        else                   row_d   = row_q + REGBITS'(1);
      end
      ST_DONE: begin
        gen_count_d = gen_count_q + CNTW'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      gen_count_q <= '0;
`ifdef GOL_TORUS_EN
      row0_save_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      gen_count_q <= gen_count_d;
`ifdef GOL_TORUS_EN
      row0_save_q <= row0_save_d;
`endif
    end
  end

  always_comb begin
    ra = '0;
    case (state_q)
      ST_LOAD_PRV: ra = LAST_ROW;
      ST_LOAD_CUR: ra = '0;
      ST_LOAD_NXT: ra = REGBITS'(1);
      ST_STEP:     ra = row_plus2;
      default:     ra = '0;
    endcase
  end

  assign regwrite  = (state_q == ST_STEP);
  assign wa        = regwrite ? row_q : '0;
  assign wd        = regwrite ? rule_row : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign gen_count = gen_count_q;

endmodule

// File: doc/gol_next_gen.md
Name: gol_next_gen

Overview:
- Generation-step sequencer for the Game of Life row store. It sits between the current-state register file and itself: it reads each row through the store's combinational read port and computes the next generation one row per cycle. Each result is written back through the store's write port.
- It keeps a three-row window of original (pre-update) rows, so in-place write-back never corrupts rows still needed.

Parameters:
- WIDTH, 8, cells per row (bits of rd/wd)
- REGBITS, 3, row address width; ROWS = 2**REGBITS
- CNTW, 16, width of generation counter

Ports:
- ph2  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request one generation step; sampled in IDLE only
- rd  input  WIDTH  row data from row store (combinational from ra)
- ra  output  REGBITS  row store read address
- wa  output  REGBITS  row store write address
- wd  output  WIDTH  next-generation row data
- regwrite  output  1  row store write enable
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  one-cycle pulse when a generation completes
- gen_count  output  CNTW  completed generations, wraps at 2**CNTW-1 -> 0

Behaviour:
- Reset (reset=0, asynchronous) has immediate effect:
  - state=IDLE; regwrite=0, busy=0, done=0, gen_count=0, ra=0, wa=0, wd=0.
  - Window registers prev/cur/nxt are cleared to 0.
  - A reset mid-sweep abandons the sweep. Rows already written stay written; no further writes occur.
- Rule: live cell survives with 2 or 3 live neighbours; dead cell becomes live with exactly 3. Neighbour count is 4-bit, 0..8.
- Out-of-grid cells are dead (no wrap) unless the optional feature is enabled.
- FSM states: IDLE, LOAD_CUR, LOAD_NXT, STEP, DONE.
  - IDLE: ra=0, regwrite=0. start=1 -> LOAD_CUR. start=0 -> stay.
  - LOAD_CUR: ra=0. At edge: cur<=rd, prev<=0, r<=0 -> LOAD_NXT.
  - LOAD_NXT: ra=1. At edge: nxt<=rd -> STEP.
  - STEP (row r): wa=r, wd=rule(prev,cur,nxt), regwrite=1, ra=r+2 (truncated).
    - At edge: prev<=cur, cur<=nxt, and nxt<=rd if r+2<ROWS, else nxt<=0.
    - r==ROWS-1 -> DONE; otherwise r<=r+1.
  - DONE: regwrite=0, done=1 for exactly one cycle, gen_count<=gen_count+1 -> IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored; it is not queued.
- Latency from start accepted to done: 2 + ROWS + 1 cycles (11 for defaults). regwrite is high for exactly ROWS consecutive cycles, with wa = 0,1,...,ROWS-1 in order.
- Read/write collision cannot occur: the read address r+2 never equals the write address r in STEP.
- All outputs are registered state or combinational decode of state and window registers only. There is no combinational path from rd to wd.

Optional Feature:
- Macro GOL_TORUS_EN.
- Defined (toroidal grid):
  - Extra state LOAD_PRV precedes LOAD_CUR: ra=ROWS-1, prev<=rd.
  - LOAD_CUR also saves the original row 0 into row0_save.
  - In STEP, when r+2>=ROWS: nxt<=row0_save when r+2==ROWS, else don't-care.
  - Horizontal neighbours of bit 0 and bit WIDTH-1 wrap to each other.
  - Latency becomes 12 cycles for defaults.
- Undefined: dead boundary as above. row0_save and LOAD_PRV are absent.

Decomposition:
- Package gol_pkg holds:
  - the state enum type (IDLE, LOAD_PRV, LOAD_CUR, LOAD_NXT, STEP, DONE);
  - default WIDTH/REGBITS constants;
  - a function for the survive/birth rule on a 4-bit count.
- Sub-module gol_row_rule (purely combinational): inputs prev, cur, nxt (WIDTH each); output new row.
  - Wrap-versus-zero edge handling is selected by GOL_TORUS_EN inside it.

Test Plan:
- Reset mid-STEP (row 3) -> all outputs 0 on the same cycle; regwrite stays 0 afterwards; gen_count=0.
- Blinker: rows all 0 except row1=00011100; pulse start.
  - Writes observed: row0=00001000, row1=00001000, row2=00001000, rows 3..7 = 0.
  - done exactly 11 cycles after start accepted; gen_count=1.
  - A second start returns row1=00011100.
- Still block: rows3,4=00011000 -> rewritten unchanged over 5 consecutive generations; gen_count=5.
- start held high continuously -> done pulses every 12 cycles (11 busy + 1 IDLE); start during busy is never double-counted.
- Edge: row4=11000001, others 0.
  - Without GOL_TORUS_EN: all rows written 0.
  - With GOL_TORUS_EN: rows 3,4,5 = 10000000.
- Vertical edge: row0=00011100.
  - Without GOL_TORUS_EN: row0=row1=00001000, row7=0.
  - With GOL_TORUS_EN: rows 7,0,1 = 00001000.
- Counter wrap: force gen_count=16'hFFFF via back-door, run one generation -> 16'h0000.
